// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store unit between a core-side request port and a
// single-ported, combinational-read data memory.
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   req, op, addr,     request (sampled only in IDLE); op encodes
//   wdata              LW/LH/LHU/LB/LBU/SW/SH/SB; wdata low bits feed sub-word stores
//   busy, done         busy outside IDLE; done is a one-cycle completion pulse
//   rdata              extended load result, held until the next good load
//   misalign           alignment error, qualified by done
//   mem_address        word-aligned address of the latched request
//   mem_writedata      word to write (sub-word stores merge into the read word)
//   mem_read/mem_write one-cycle memory strobes, never both high
//   mem_readdata       combinational memory read data
//
// Flow: aligned loads IDLE->RD->RESP, SW IDLE->WR->RESP, SH/SB do a
// read-modify-write IDLE->RD->WR->RESP, misaligned requests skip straight
// to RESP without touching memory.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writedata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_readdata
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;     // word read during RD, base for sub-word stores
    logic        mis_q;
    logic [31:0] rdata_q;

    logic        mis_in;
    logic        is_load_in;
    logic [31:0] load_val;
    logic [31:0] merged;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Alignment check on the incoming request so the branch can be taken
    // directly from IDLE.
    always_comb begin
        mis_in = 1'b0;
        case (op)
            OP_LW, OP_SW:         mis_in = (addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: mis_in = addr[0];
            default:              mis_in = 1'b0;
        endcase
    end

    assign is_load_in = (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
                        (op == OP_LB) || (op == OP_LBU);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (mis_in)          state_d = RESP;
                    else if (is_load_in) state_d = RD;
                    else if (op == OP_SW) state_d = WR;
                    else                 state_d = RD;   // SH/SB read-modify-write
                end
            end
            RD:      state_d = ((op_q == OP_SH) || (op_q == OP_SB)) ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane selection on the live read data, little-endian
    always_comb begin
        byte_sel = mem_readdata[7:0];
        case (addr_q[1:0])
            2'd0: byte_sel = mem_readdata[7:0];
            2'd1: byte_sel = mem_readdata[15:8];
            2'd2: byte_sel = mem_readdata[23:16];
            2'd3: byte_sel = mem_readdata[31:24];
            default: byte_sel = mem_readdata[7:0];
        endcase
        half_sel = addr_q[1] ? mem_readdata[31:16] : mem_readdata[15:0];
    end

    always_comb begin
        load_val = mem_readdata;
        case (op_q)
            OP_LW:   load_val = mem_readdata;
            OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_val = {16'h0000, half_sel};
            OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_val = {24'h000000, byte_sel};
            default: load_val = mem_readdata;
        endcase
    end

    // Sub-word store merge into the captured word
    always_comb begin
        merged = word_q;
        if (op_q == OP_SB) begin
            case (addr_q[1:0])
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
                default: merged = word_q;
            endcase
        end else if (op_q == OP_SH) begin
            if (addr_q[1]) merged[31:16] = wdata_q[15:0];
            else           merged[15:0]  = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            word_q  <= 32'h0;
            mis_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && req) begin
                op_q    <= op;
                addr_q  <= addr;
                wdata_q <= wdata;
                mis_q   <= mis_in;
            end
            if (state_q == RD) begin
                word_q <= mem_readdata;
                // RD is only reached by aligned requests, so a load here is good
                if ((op_q != OP_SW) && (op_q != OP_SH) && (op_q != OP_SB))
                    rdata_q <= load_val;
            end
        end
    end

    assign busy          = (state_q != IDLE);
    assign done          = (state_q == RESP);
    assign misalign      = done & mis_q;
    assign rdata         = rdata_q;
    assign mem_read      = (state_q == RD);
    assign mem_write     = (state_q == WR);
    assign mem_address   = {addr_q[31:2], 2'b00};
    assign mem_writedata = ((op_q == OP_SH) || (op_q == OP_SB)) ? merged : wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, req;
    logic [2:0]  op;
    logic [31:0] addr, wdata, rdata, mem_address, mem_writedata, mem_readdata;
    logic        busy, done, misalign, mem_read, mem_write;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .misalign(misalign),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_readdata(mem_readdata)
    );

    // 64-word memory stub; address bits above [7:2] alias
    logic [31:0] tb_mem [0:63];
    logic [31:0] ref_mem [0:63];
    logic        pl_we = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_val = 32'h0;

    assign mem_readdata = tb_mem[mem_address[7:2]];
    always @(posedge clk) begin
        if (pl_we)          tb_mem[pl_idx] <= pl_val;
        else if (mem_write) tb_mem[mem_address[7:2]] <= mem_writedata;
    end

    int nvec = 0, nfail = 0;
    int wr_cnt = 0, done_cnt = 0;
    always @(posedge clk) begin
        if (mem_write) wr_cnt <= wr_cnt + 1;
        if (done)      done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---- transaction-level reference model ----
    typedef struct {
        logic        busy, done, rd, wr, mis;
        logic [31:0] rdata, maddr, mwdata;
    } exp_t;
    exp_t        expq[$];
    logic [31:0] m_rdata = 32'h0;
    bit          chk_on = 1'b0;

    function automatic bit is_misal(input logic [2:0] o, input logic [31:0] a);
        if (o == 3'd0 || o == 3'd5) return a[1:0] != 2'b00;
        if (o == 3'd1 || o == 3'd2 || o == 3'd6) return a[0];
        return 1'b0;
    endfunction

    function automatic logic [31:0] ld_model(input logic [2:0] o, input logic [31:0] w,
                                             input logic [1:0] off);
        logic [31:0] s;
        s = w >> (8 * off);
        case (o)
            3'd1:    return {{16{s[15]}}, s[15:0]};
            3'd2:    return {16'h0, s[15:0]};
            3'd3:    return {{24{s[7]}}, s[7:0]};
            3'd4:    return {24'h0, s[7:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] st_merge(input logic [2:0] o, input logic [31:0] w,
                                             input logic [31:0] d, input logic [1:0] off);
        logic [31:0] m;
        m = (o == 3'd7) ? 32'h000000FF : 32'h0000FFFF;
        return (w & ~(m << (8 * off))) | ((d & m) << (8 * off));
    endfunction

    function automatic exp_t mk(input logic b, input logic dn, input logic r, input logic w,
                                input logic mi, input logic [31:0] rd,
                                input logic [31:0] ma, input logic [31:0] wd);
        exp_t e;
        e.busy = b; e.done = dn; e.rd = r; e.wr = w; e.mis = mi;
        e.rdata = rd; e.maddr = ma; e.mwdata = wd;
        return e;
    endfunction

    // Per-cycle compare against the model's expected schedule
    always @(negedge clk) begin
        if (chk_on) begin
            exp_t e;
            if (expq.size() > 0) e = expq.pop_front();
            else e = mk(0, 0, 0, 0, 0, m_rdata, 32'h0, 32'h0);
            chk("busy", {31'h0, busy}, {31'h0, e.busy});
            chk("done", {31'h0, done}, {31'h0, e.done});
            chk("mem_read", {31'h0, mem_read}, {31'h0, e.rd});
            chk("mem_write", {31'h0, mem_write}, {31'h0, e.wr});
            chk("rdata", rdata, e.rdata);
            if (e.done) chk("misalign", {31'h0, misalign}, {31'h0, e.mis});
            if (e.rd || e.wr) chk("mem_address", mem_address, e.maddr);
            if (e.wr) chk("mem_writedata", mem_writedata, e.mwdata);
        end
    end

    task automatic poke(input int i, input logic [31:0] v);
        @(negedge clk);
        pl_we = 1'b1; pl_idx = 6'(i); pl_val = v;
        ref_mem[i] = v;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    task automatic txn(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                       input bit hold, input bit glitch);
        int          len;
        logic [5:0]  idx;
        logic [31:0] ma, w, nv;
        @(negedge clk);
        req = 1'b1; op = o; addr = a; wdata = d;
        @(posedge clk); #1;
        idx = a[7:2];
        ma  = {a[31:2], 2'b00};
        w   = ref_mem[idx];
        if (is_misal(o, a)) begin
            expq.push_back(mk(1, 1, 0, 0, 1, m_rdata, ma, 32'h0));
            len = 1;
        end else if (o <= 3'd4) begin
            nv = ld_model(o, w, a[1:0]);
            expq.push_back(mk(1, 0, 1, 0, 0, m_rdata, ma, 32'h0));
            expq.push_back(mk(1, 1, 0, 0, 0, nv, ma, 32'h0));
            m_rdata = nv;
            len = 2;
        end else if (o == 3'd5) begin
            expq.push_back(mk(1, 0, 0, 1, 0, m_rdata, ma, d));
            expq.push_back(mk(1, 1, 0, 0, 0, m_rdata, ma, 32'h0));
            ref_mem[idx] = d;
            len = 2;
        end else begin
            nv = st_merge(o, w, d, a[1:0]);
            expq.push_back(mk(1, 0, 1, 0, 0, m_rdata, ma, 32'h0));
            expq.push_back(mk(1, 0, 0, 1, 0, m_rdata, ma, nv));
            expq.push_back(mk(1, 1, 0, 0, 0, m_rdata, ma, 32'h0));
            ref_mem[idx] = nv;
            len = 3;
        end
        if (!hold) req = 1'b0;
        if (glitch) begin
            // a stray store request while busy must be ignored
            req = 1'b1; op = 3'd5; addr = 32'h10; wdata = 32'hBAD0BAD0;
            @(posedge clk); #1;
            req = 1'b0;
            len--;
        end
        repeat (len) @(posedge clk);
        #1;
        chk("memword", tb_mem[idx], ref_mem[idx]);
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; op = 3'd0; addr = 32'h0; wdata = 32'h0;
        for (int i = 0; i < 64; i++) poke(i, $urandom);
        poke(4, 32'h8899AABB);
        @(posedge clk); #1;
        chk("rst busy", {31'h0, busy}, 32'h0);
        chk("rst done", {31'h0, done}, 32'h0);
        chk("rst misalign", {31'h0, misalign}, 32'h0);
        chk("rst rdata", rdata, 32'h0);
        chk("rst strobes", {30'h0, mem_read, mem_write}, 32'h0);
        chk("rst mem_address", mem_address, 32'h0);
        chk("rst mem_writedata", mem_writedata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        m_rdata = 32'h0;
        chk_on = 1'b1;

        // hand-computed expectations
        txn(3'd3, 32'h13, 32'h0, 0, 0); chk("LB 0x13", rdata, 32'hFFFFFF88);
        txn(3'd4, 32'h13, 32'h0, 0, 0); chk("LBU 0x13", rdata, 32'h00000088);
        txn(3'd1, 32'h12, 32'h0, 0, 0); chk("LH 0x12", rdata, 32'hFFFF8899);
        txn(3'd2, 32'h10, 32'h0, 0, 0); chk("LHU 0x10", rdata, 32'h0000AABB);
        txn(3'd0, 32'h10, 32'h0, 0, 0); chk("LW 0x10", rdata, 32'h8899AABB);
        begin
            int w0;
            w0 = wr_cnt;
            txn(3'd7, 32'h11, 32'h123456CC, 0, 0);
            chk("SB word", tb_mem[4], 32'h8899CCBB);
            chk("SB wr count", 32'(wr_cnt - w0), 32'd1);
        end
        txn(3'd5, 32'h10, 32'hDEADBEEF, 0, 0);
        txn(3'd0, 32'h10, 32'h0, 0, 0); chk("SW readback", rdata, 32'hDEADBEEF);
        txn(3'd0, 32'h0E, 32'h0, 0, 0); chk("LW 0x0E rdata", rdata, 32'hDEADBEEF);
        txn(3'd6, 32'h11, 32'h5555, 0, 0); chk("SH 0x11 word", tb_mem[4], 32'hDEADBEEF);

        // back-to-back with req held, and req pulsed while busy
        txn(3'd0, 32'h20, 32'h0, 1, 0);
        txn(3'd0, 32'h24, 32'h0, 0, 0);
        txn(3'd0, 32'h10, 32'h0, 0, 1);
        chk("glitch word", tb_mem[4], 32'hDEADBEEF);

        // top-of-address-space wrap
        txn(3'd5, 32'hFFFFFFFC, 32'hCAFEF00D, 0, 0);
        txn(3'd0, 32'hFFFFFFFC, 32'h0, 0, 0); chk("LW top", rdata, 32'hCAFEF00D);

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            logic [2:0]  o;
            logic [31:0] a;
            o = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFFC | 32'($urandom_range(0, 3)))
                                            : 32'($urandom_range(0, 255));
            txn(o, a, $urandom, 0, (n % 17) == 5);
        end

        // reset during RD of SH 0x10
        chk_on = 1'b0;
        begin
            int w0, d0;
            logic [31:0] old;
            old = tb_mem[4];
            @(negedge clk);
            req = 1'b1; op = 3'd6; addr = 32'h10; wdata = 32'h00001234;
            @(posedge clk); #1;
            req = 1'b0;
            chk("RD before reset", {31'h0, mem_read}, 32'h1);
            w0 = wr_cnt; d0 = done_cnt;
            rst_n = 1'b0;
            @(posedge clk); #1;
            chk("post-rst busy/done/mis", {29'h0, busy, done, misalign}, 32'h0);
            chk("post-rst strobes", {30'h0, mem_read, mem_write}, 32'h0);
            chk("post-rst rdata", rdata, 32'h0);
            chk("post-rst mem_address", mem_address, 32'h0);
            chk("post-rst mem_writedata", mem_writedata, 32'h0);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            chk("rst no write", 32'(wr_cnt - w0), 32'd0);
            chk("rst no done", 32'(done_cnt - d0), 32'd0);
            chk("rst word kept", tb_mem[4], old);
            m_rdata = 32'h0;
        end
        chk_on = 1'b1;
        txn(3'd0, 32'h10, 32'h0, 0, 0);
        chk("after reset LW", rdata, ref_mem[4]);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
